// File: rtl/branch_resolve_queue_if.sv
// Handshake bundle between IF/issue, RoB commit and the branch resolve queue.
interface branch_resolve_queue_if;
    logic        push_en;
    logic [31:0] push_PC;
    logic        push_pred;
    logic [31:0] push_alt_PC;
    logic        full_out;
    logic        empty_out;
    logic        resolve_en;
    logic        resolve_taken;
    logic        update_en;
    logic [31:0] update_PC;
    logic        update_result;
    logic        flush_out;
    logic [31:0] redirect_PC_out;

    modport master (
        output push_en, push_PC, push_pred, push_alt_PC, resolve_en, resolve_taken,
        input  full_out, empty_out, update_en, update_PC, update_result, flush_out,
               redirect_PC_out
    );

    modport slave (
        input  push_en, push_PC, push_pred, push_alt_PC, resolve_en, resolve_taken,
        output full_out, empty_out, update_en, update_PC, update_result, flush_out,
               redirect_PC_out
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; drives predictor updates and mispredict flushes.
// Define BRQ_STATS_EN to add resolved-branch and mispredict counters.
module branch_resolve_queue #(
    parameter int unsigned DEPTH_WIDTH = 3,
    parameter int unsigned DEPTH       = 1 << DEPTH_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
`ifdef BRQ_STATS_EN
    output logic [31:0]           stat_branches_out,
    output logic [31:0]           stat_mispredicts_out,
`endif
    branch_resolve_queue_if.slave brq
);

    localparam int unsigned CntW = DEPTH_WIDTH + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

    logic [31:0]            pc_mem   [DEPTH];
    logic [31:0]            alt_mem  [DEPTH];
    logic                   pred_mem [DEPTH];

    logic [DEPTH_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]        count_q, count_d;
    logic                   update_en_q, update_en_d;
    logic [31:0]            update_pc_q, update_pc_d;
    logic                   update_result_q, update_result_d;
    logic                   flush_q, flush_d;
    logic [31:0]            redirect_q, redirect_d;

    logic full, empty, push_ok, res_ok, mispredict;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);

    // A mispredict empties the queue, so a same-cycle push must not land.
    assign res_ok     = rdy_in & brq.resolve_en & ~empty & ~flush_q;
    assign mispredict = res_ok & (brq.resolve_taken != pred_mem[head_q]);
    assign push_ok    = rdy_in & brq.push_en & ~full & ~flush_q & ~mispredict;

    always_comb begin
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        update_en_d     = 1'b0;
        update_pc_d     = update_pc_q;
        update_result_d = update_result_q;
        flush_d         = 1'b0;
        redirect_d      = redirect_q;
        if (mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + DEPTH_WIDTH'(res_ok);
            tail_d  = tail_q + DEPTH_WIDTH'(push_ok);
            count_d = count_q + CntW'(push_ok) - CntW'(res_ok);
        end
        if (res_ok) begin
            update_en_d     = 1'b1;
            update_pc_d     = pc_mem[head_q];
            update_result_d = brq.resolve_taken;
        end
        if (mispredict) begin
            flush_d    = 1'b1;
            redirect_d = alt_mem[head_q];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            update_en_q     <= 1'b0;
            update_pc_q     <= '0;
            update_result_q <= 1'b0;
            flush_q         <= 1'b0;
            redirect_q      <= '0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            update_en_q     <= update_en_d;
            update_pc_q     <= update_pc_d;
            update_result_q <= update_result_d;
            flush_q         <= flush_d;
            redirect_q      <= redirect_d;
        end
    end

    // Entry storage needs no reset: validity is tracked by the pointers.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            pc_mem[tail_q]   <= brq.push_PC;
            alt_mem[tail_q]  <= brq.push_alt_PC;
            pred_mem[tail_q] <= brq.push_pred;
        end
    end

    assign brq.full_out        = full;
    assign brq.empty_out       = empty;
    assign brq.update_en       = update_en_q;
    assign brq.update_PC       = update_pc_q;
    assign brq.update_result   = update_result_q;
    assign brq.flush_out       = flush_q;
    assign brq.redirect_PC_out = redirect_q;

`ifdef BRQ_STATS_EN
    logic [31:0] stat_branches_q, stat_mispredicts_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (res_ok)     stat_branches_q    <= stat_branches_q + 32'd1;
            if (mispredict) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
        end
    end

    assign stat_branches_out    = stat_branches_q;
    assign stat_mispredicts_out = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Table-driven bench for branch_resolve_queue with an update scoreboard.
module tb_branch_resolve_queue;

    typedef struct {
        bit          rdy;
        bit          push;
        logic [31:0] pc;
        bit          pred;
        logic [31:0] alt;
        bit          res;
        bit          taken;
        bit          upd;
        logic [31:0] upc;
        bit          ures;
        bit          fl;
        logic [31:0] redir;
        bit          emp;
        bit          ful;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        bit          res;
        bit          fl;
        logic [31:0] redir;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;

    int checks = 0;
    int passes = 0;

    exp_t sb[$];
    vec_t phase1[$];
    vec_t phase2[$];

    branch_resolve_queue_if bif ();

`ifdef BRQ_STATS_EN
    logic [31:0] stat_b, stat_m;
`endif

    branch_resolve_queue dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
`ifdef BRQ_STATS_EN
        .stat_branches_out    (stat_b),
        .stat_mispredicts_out (stat_m),
`endif
        .brq    (bif)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(bit rdy, bit push, logic [31:0] pc, bit pred, logic [31:0] alt,
                                bit res, bit taken, bit upd, logic [31:0] upc, bit ures,
                                bit fl, logic [31:0] redir, bit emp, bit ful);
        vec_t v;
        v.rdy = rdy; v.push = push; v.pc = pc; v.pred = pred; v.alt = alt;
        v.res = res; v.taken = taken; v.upd = upd; v.upc = upc; v.ures = ures;
        v.fl = fl; v.redir = redir; v.emp = emp; v.ful = ful;
        return v;
    endfunction

    // Shorthands: push-only, resolve-only and idle cycles with rdy high.
    function automatic vec_t vp(logic [31:0] pc, bit pred, logic [31:0] alt, bit emp, bit ful);
        return mk(1, 1, pc, pred, alt, 0, 0, 0, 0, 0, 0, 0, emp, ful);
    endfunction

    function automatic vec_t vr(bit taken, logic [31:0] upc, bit fl, logic [31:0] redir,
                                bit emp, bit ful);
        return mk(1, 0, 0, 0, 0, 1, taken, 1, upc, taken, fl, redir, emp, ful);
    endfunction

    // Called at a negedge; the edge in between applies the vector.
    task automatic step(input vec_t v);
        rdy_in            = v.rdy;
        bif.push_en       = v.push;
        bif.push_PC       = v.pc;
        bif.push_pred     = v.pred;
        bif.push_alt_PC   = v.alt;
        bif.resolve_en    = v.res;
        bif.resolve_taken = v.taken;
        if (v.upd) sb.push_back('{pc: v.upc, res: v.ures, fl: v.fl, redir: v.redir});
        @(negedge clk_in);
        chk("empty_out", 32'(bif.empty_out), 32'(v.emp));
        chk("full_out", 32'(bif.full_out), 32'(v.ful));
        chk("update_en", 32'(bif.update_en), 32'(v.upd));
        chk("flush_out", 32'(bif.flush_out), 32'(v.fl));
    endtask

    task automatic idle_inputs();
        rdy_in            = 1'b1;
        bif.push_en       = 1'b0;
        bif.push_PC       = '0;
        bif.push_pred     = 1'b0;
        bif.push_alt_PC   = '0;
        bif.resolve_en    = 1'b0;
        bif.resolve_taken = 1'b0;
    endtask

    // Scoreboard: every update pulse must match the oldest expected resolve.
    always @(negedge clk_in) begin
        if (rst_in && bif.update_en) begin
            if (sb.size() == 0) begin
                chk("unexpected_update_en", 32'(bif.update_en), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("update_PC", bif.update_PC, e.pc);
                chk("update_result", 32'(bif.update_result), 32'(e.res));
                chk("sb_flush_out", 32'(bif.flush_out), 32'(e.fl));
                if (e.fl) chk("redirect_PC_out", bif.redirect_PC_out, e.redir);
            end
        end
    end

    initial begin
        idle_inputs();

        // Single predicted-correct branch.
        phase1.push_back(vp(32'h100, 1, 32'h104, 0, 0));
        phase1.push_back(vr(1, 32'h100, 0, 0, 1, 0));
        // Fill to full (pointers start mid-ring), drop pushes while full.
        for (int i = 0; i < 8; i++)
            phase1.push_back(vp(32'(i * 4), 0, 32'(i * 4 + 'h40), 0, i == 7));
        phase1.push_back(vp(32'h20, 0, 32'h60, 0, 1));
        phase1.push_back(mk(1, 1, 32'h24, 0, 32'h64, 1, 0, 1, 32'h0, 0, 0, 0, 0, 0));
        for (int i = 1; i < 8; i++)
            phase1.push_back(vr(0, 32'(i * 4), 0, 0, i == 7, 0));
        // Mispredict with a same-cycle push, then inputs ignored in the flush cycle.
        phase1.push_back(vp(32'h200, 0, 32'h280, 0, 0));
        phase1.push_back(vp(32'h300, 0, 32'h380, 0, 0));
        phase1.push_back(mk(1, 1, 32'h400, 0, 32'h480, 1, 1, 1, 32'h200, 1, 1, 32'h280, 1, 0));
        phase1.push_back(mk(1, 1, 32'h500, 0, 32'h580, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        phase1.push_back(vp(32'h600, 0, 32'h604, 0, 0));
        phase1.push_back(vr(0, 32'h600, 0, 0, 1, 0));
        // Three queued, push+resolve keeps count at 3: full only after five more pushes.
        phase1.push_back(vp(32'h700, 1, 32'h704, 0, 0));
        phase1.push_back(vp(32'h704, 1, 32'h708, 0, 0));
        phase1.push_back(vp(32'h708, 1, 32'h70C, 0, 0));
        phase1.push_back(mk(1, 1, 32'h70C, 1, 32'h710, 1, 1, 1, 32'h700, 1, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            phase1.push_back(vp(32'h710 + 32'(i * 4), 1, 32'h714 + 32'(i * 4), 0, i == 4));
        // Pause with live requests: nothing may move.
        for (int i = 0; i < 4; i++)
            phase1.push_back(mk(0, 1, 32'h800, 0, 32'h880, 1, 0, 0, 0, 0, 0, 0, 0, 1));

        // Stats sequence: 5 resolves, 2 mispredicts.
        phase2.push_back(vp(32'h900, 1, 32'h904, 0, 0));
        phase2.push_back(vr(1, 32'h900, 0, 0, 1, 0));
        phase2.push_back(vp(32'h910, 0, 32'h980, 0, 0));
        phase2.push_back(vr(1, 32'h910, 1, 32'h980, 1, 0));
        phase2.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        phase2.push_back(vp(32'h920, 1, 32'h924, 0, 0));
        phase2.push_back(vr(0, 32'h920, 1, 32'h924, 1, 0));
        phase2.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        phase2.push_back(vp(32'h930, 0, 32'h9A0, 0, 0));
        phase2.push_back(vr(0, 32'h930, 0, 0, 1, 0));
        phase2.push_back(vp(32'h940, 1, 32'h944, 0, 0));
        phase2.push_back(vr(1, 32'h940, 0, 0, 1, 0));

        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("rst_empty_out", 32'(bif.empty_out), 32'd1);
        chk("rst_full_out", 32'(bif.full_out), 32'd0);
        chk("rst_update_en", 32'(bif.update_en), 32'd0);
        chk("rst_flush_out", 32'(bif.flush_out), 32'd0);
        chk("rst_update_PC", bif.update_PC, 32'd0);
        chk("rst_update_result", 32'(bif.update_result), 32'd0);
        chk("rst_redirect_PC_out", bif.redirect_PC_out, 32'd0);

        foreach (phase1[i]) step(phase1[i]);
        chk("pause_update_PC_held", bif.update_PC, 32'h700);

        // Held entries resume in order after the pause.
        step(mk(1, 0, 0, 0, 0, 1, 1, 1, 32'h704, 1, 0, 0, 0, 0));

        // Asynchronous reset between edges with entries queued and a pulse live.
        idle_inputs();
        #2 rst_in = 1'b0;
        #1;
        chk("async_rst_empty_out", 32'(bif.empty_out), 32'd1);
        chk("async_rst_full_out", 32'(bif.full_out), 32'd0);
        chk("async_rst_update_en", 32'(bif.update_en), 32'd0);
        chk("async_rst_update_PC", bif.update_PC, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("post_rst_empty_out", 32'(bif.empty_out), 32'd1);

        foreach (phase2[i]) step(phase2[i]);
        chk("redirect_PC_held", bif.redirect_PC_out, 32'h924);
`ifdef BRQ_STATS_EN
        chk("stat_branches_out", stat_b, 32'd5);
        chk("stat_mispredicts_out", stat_m, 32'd2);
`endif

        idle_inputs();
        repeat (2) @(negedge clk_in);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
